// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with hazard hold, memory stall and flush.
// SKID=1 adds a second entry so that upstream ready comes straight from a flop.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int unsigned       SKID      = 1,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              hold_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    logic              r_head_valid;
    logic [DATA_W-1:0] r_head_data;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_frz;
    logic              w_deq;
    logic              w_enq;
    logic              w_in_ready;
    logic              w_skid_valid;
    logic [1:0]        w_occ;
    logic              w_flush_hit;

    assign w_frz = hold_i | stall_i;
    assign w_deq = r_head_valid & out_ready_i & ~w_frz;
    assign w_enq = in_valid_i & w_in_ready & ~w_frz & ~flush_i;

    generate
        if (SKID != 0) begin : g_skid
            logic              r_skid_valid;
            logic [DATA_W-1:0] r_skid_data;

            // Skid entry only fills while the head is occupied, so it doubles
            // as the registered "full" flag that drives upstream ready.
            assign w_in_ready   = ~r_skid_valid;
            assign w_skid_valid = r_skid_valid;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_head_valid <= 1'b0;
                    r_head_data  <= FLUSH_VAL;
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= FLUSH_VAL;
                end else if (flush_i) begin
                    r_head_valid <= 1'b0;
                    r_head_data  <= FLUSH_VAL;
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= FLUSH_VAL;
                end else if (w_deq) begin
                    if (r_skid_valid) begin
                        r_head_data  <= r_skid_data;
                        r_skid_valid <= 1'b0;
                    end else if (w_enq) begin
                        r_head_data <= in_data_i;
                    end else begin
                        r_head_valid <= 1'b0;
                    end
                end else if (w_enq) begin
                    if (r_head_valid) begin
                        r_skid_data  <= in_data_i;
                        r_skid_valid <= 1'b1;
                    end else begin
                        r_head_data  <= in_data_i;
                        r_head_valid <= 1'b1;
                    end
                end
            end
        end else begin : g_noskid
            assign w_in_ready   = ~w_frz & (~r_head_valid | out_ready_i);
            assign w_skid_valid = 1'b0;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_head_valid <= 1'b0;
                    r_head_data  <= FLUSH_VAL;
                end else if (flush_i) begin
                    r_head_valid <= 1'b0;
                    r_head_data  <= FLUSH_VAL;
                end else if (w_enq) begin
                    r_head_valid <= 1'b1;
                    r_head_data  <= in_data_i;
                end else if (w_deq) begin
                    r_head_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign w_occ = {1'b0, r_head_valid} + {1'b0, w_skid_valid};

    // Only flushes that actually kill something (held or offered) are counted.
    assign w_flush_hit = flush_i & ((w_occ != 2'd0) | in_valid_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_flush_cnt <= '0;
        end else if (w_flush_hit && !(&r_flush_cnt)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_head_valid;
    assign out_data_o  = r_head_data;
    assign occ_o       = w_occ;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1/64-bit instance and a SKID=0/16-bit instance,
// both checked against queue-based models of the stage.
module tb_pipe_stage_reg;

    logic clk;
    logic rst;

    // SKID=1 instance (a_*)
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic        a_hold, a_stall, a_flush;
    logic [63:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_cnt;

    // SKID=0 instance (b_*)
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic        b_hold, b_stall, b_flush;
    logic [15:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [3:0]  b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] ma_q[$];
    int          ma_cnt;
    logic [15:0] mb_q[$];
    int          mb_cnt;

    localparam logic [15:0] B_FV = 16'hDEAD;
    logic [63:0] pa;
    logic [63:0] pb;
    logic [63:0] pc;
    logic [63:0] pd;

    pipe_stage_reg #(.DATA_W(64), .FLUSH_VAL(64'h0), .SKID(1), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
        .hold_i(a_hold), .stall_i(a_stall), .flush_i(a_flush),
        .occ_o(a_occ), .flush_cnt_o(a_cnt)
    );

    pipe_stage_reg #(.DATA_W(16), .FLUSH_VAL(B_FV), .SKID(0), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
        .hold_i(b_hold), .stall_i(b_stall), .flush_i(b_flush),
        .occ_o(b_occ), .flush_cnt_o(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_hold = 0; a_stall = 0; a_flush = 0;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_hold = 0; b_stall = 0; b_flush = 0;
    endtask

    // Advance both models by the rules of the stage, then clock the DUTs.
    task automatic step();
        bit frz, rdy, deq, enq;
        if (rst) begin
            ma_q.delete(); mb_q.delete(); ma_cnt = 0; mb_cnt = 0;
        end else begin
            frz = a_hold | a_stall;
            rdy = (ma_q.size() < 2);
            deq = (ma_q.size() > 0) && a_out_ready && !frz;
            enq = a_in_valid && rdy && !frz && !a_flush;
            if (a_flush) begin
                if ((ma_q.size() != 0 || a_in_valid) && ma_cnt < 65535) ma_cnt++;
                ma_q.delete();
            end else begin
                if (deq) void'(ma_q.pop_front());
                if (enq) ma_q.push_back(a_in_data);
            end
            frz = b_hold | b_stall;
            rdy = !frz && (mb_q.size() == 0 || b_out_ready);
            deq = (mb_q.size() > 0) && b_out_ready && !frz;
            enq = b_in_valid && rdy && !frz && !b_flush;
            if (b_flush) begin
                if ((mb_q.size() != 0 || b_in_valid) && mb_cnt < 15) mb_cnt++;
                mb_q.delete();
            end else begin
                if (deq) void'(mb_q.pop_front());
                if (enq) mb_q.push_back(b_in_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid: got %b want 0", a_out_valid); end
        n_checks++; if (a_out_data !== 64'h0) begin n_fail++; $display("FAIL reset_a_data: got %h want 0", a_out_data); end
        n_checks++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL reset_a_occ: got %0d want 0", a_occ); end
        n_checks++; if (a_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_a_cnt: got %0d want 0", a_cnt); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_ready: got %b want 1", a_in_ready); end
        n_checks++; if (b_out_data !== B_FV) begin n_fail++; $display("FAIL reset_b_data: got %h want %h", b_out_data, B_FV); end
        n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_ready: got %b want 1", b_in_ready); end
        rst = 0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [63:0] exp_v[4];
        exp_v[0] = pa; exp_v[1] = pb; exp_v[2] = pc; exp_v[3] = pd;
        idle(); a_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1; a_in_data = exp_v[i];
            step();
            n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp_v[i]) begin n_fail++; $display("FAIL basic_data%0d: got v=%b %h want v=1 %h", i, a_out_valid, a_out_data, exp_v[i]); end
            n_checks++; if (a_occ !== 2'd1) begin n_fail++; $display("FAIL basic_occ%0d: got %0d want 1", i, a_occ); end
        end
        a_in_valid = 0;
        step();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", a_out_valid); end
        $display("test_basic done");
    endtask

    task automatic test_skid_fill();
        idle();
        a_in_valid = 1; a_in_data = pa; step();
        a_in_data = pb; step();
        n_checks++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL skid_occ: got %0d want 2", a_occ); end
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_ready: got %b want 0", a_in_ready); end
        a_in_data = pc; step();
        n_checks++; if (a_occ !== 2'd2 || a_out_data !== pa) begin n_fail++; $display("FAIL skid_c_refused: got occ=%0d %h want occ=2 %h", a_occ, a_out_data, pa); end
        a_out_ready = 1; step();
        n_checks++; if (a_out_data !== pb) begin n_fail++; $display("FAIL skid_second: got %h want %h", a_out_data, pb); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_back: got %b want 1", a_in_ready); end
        step();
        n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== pc) begin n_fail++; $display("FAIL skid_third: got v=%b %h want v=1 %h", a_out_valid, a_out_data, pc); end
        a_in_valid = 0; step();
        n_checks++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL skid_empty: got %0d want 0", a_occ); end
        $display("test_skid_fill done");
    endtask

    task automatic test_freeze();
        for (int v = 0; v < 2; v++) begin
            idle();
            a_in_valid = 1; a_in_data = pa; step();
            a_in_data = pb; a_out_ready = 1;
            if (v == 0) a_stall = 1; else a_hold = 1;
            for (int c = 0; c < 3; c++) begin
                step();
                n_checks++; if (a_out_data !== pa || a_occ !== 2'd1 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL freeze%0d_c%0d: got %h occ=%0d rdy=%b want %h occ=1 rdy=1", v, c, a_out_data, a_occ, a_in_ready, pa); end
            end
            a_stall = 0; a_hold = 0; step();
            n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== pb) begin n_fail++; $display("FAIL freeze%0d_release: got v=%b %h want v=1 %h", v, a_out_valid, a_out_data, pb); end
            a_in_valid = 0; step();
            n_checks++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL freeze%0d_drain: got %0d want 0", v, a_occ); end
        end
        $display("test_freeze done");
    endtask

    task automatic test_flush();
        idle();
        a_in_valid = 1; a_in_data = pa; step();
        a_in_data = pb; step();
        a_in_data = pc; a_flush = 1; a_hold = 1; step();
        n_checks++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_occ: got occ=%0d v=%b want occ=0 v=0", a_occ, a_out_valid); end
        n_checks++; if (a_out_data !== 64'h0) begin n_fail++; $display("FAIL flush_data: got %h want 0", a_out_data); end
        n_checks++; if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_cnt: got %0d want 1", a_cnt); end
        idle(); a_out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_c_leak%0d: got %b want 0", c, a_out_valid); end
        end
        idle(); a_flush = 1; b_flush = 1; step();
        n_checks++; if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_empty_a: got %0d want 1", a_cnt); end
        n_checks++; if (b_cnt !== 4'd0) begin n_fail++; $display("FAIL flush_empty_b: got %0d want 0", b_cnt); end
        $display("test_flush done");
    endtask

    task automatic test_cnt_saturate();
        idle(); b_in_valid = 1; b_flush = 1;
        for (int c = 0; c < 20; c++) step();
        n_checks++; if (b_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_reach: got %0d want 15", b_cnt); end
        idle(); b_in_valid = 1; b_in_data = 16'h1234; step();
        b_in_valid = 0; b_flush = 1; step();
        n_checks++; if (b_cnt !== 4'hF || b_out_data !== B_FV) begin n_fail++; $display("FAIL sat_hold: got cnt=%0d %h want cnt=15 %h", b_cnt, b_out_data, B_FV); end
        $display("test_cnt_saturate done");
    endtask

    task automatic test_async_reset();
        idle();
        a_in_valid = 1; a_in_data = pd; b_in_valid = 1; b_in_data = 16'h5A5A; step();
        idle();
        n_checks++; if (a_occ !== 2'd1 || b_occ !== 2'd1) begin n_fail++; $display("FAIL areset_pre: got a=%0d b=%0d want 1 1", a_occ, b_occ); end
        @(negedge clk); rst = 1; #1;
        n_checks++; if (a_out_valid !== 1'b0 || a_out_data !== 64'h0 || a_occ !== 2'd0) begin n_fail++; $display("FAIL areset_a: got v=%b %h occ=%0d want 0 0 0", a_out_valid, a_out_data, a_occ); end
        n_checks++; if (b_out_valid !== 1'b0 || b_out_data !== B_FV) begin n_fail++; $display("FAIL areset_b: got v=%b %h want 0 %h", b_out_valid, b_out_data, B_FV); end
        n_checks++; if (a_cnt !== 16'd0 || b_cnt !== 4'd0) begin n_fail++; $display("FAIL areset_cnt: got %0d %0d want 0 0", a_cnt, b_cnt); end
        ma_q.delete(); mb_q.delete(); ma_cnt = 0; mb_cnt = 0;
        #1 rst = 0;
        step();
        $display("test_async_reset done");
    endtask

    task automatic test_skid0();
        idle();
        b_in_valid = 1; b_in_data = 16'hA0A0; step();
        b_in_data = 16'hB0B0; #1;
        n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL s0_full_notready: got %b want 0", b_in_ready); end
        b_out_ready = 1; #1;
        n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL s0_full_ready: got %b want 1", b_in_ready); end
        b_stall = 1; #1;
        n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL s0_frz_ready: got %b want 0", b_in_ready); end
        b_stall = 0;
        step();
        n_checks++; if (b_out_valid !== 1'b1 || b_out_data !== 16'hB0B0 || b_occ !== 2'd1) begin n_fail++; $display("FAIL s0_reload: got v=%b %h occ=%0d want 1 b0b0 1", b_out_valid, b_out_data, b_occ); end
        idle(); b_out_ready = 1; step();
        $display("test_skid0 done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            a_in_valid = ($urandom_range(0, 1) == 1); a_in_data = {$urandom, $urandom};
            a_out_ready = ($urandom_range(0, 9) < 6); a_hold = ($urandom_range(0, 7) == 0);
            a_stall = ($urandom_range(0, 7) == 0); a_flush = ($urandom_range(0, 15) == 0);
            b_in_valid = ($urandom_range(0, 1) == 1); b_in_data = 16'($urandom);
            b_out_ready = ($urandom_range(0, 9) < 6); b_hold = ($urandom_range(0, 7) == 0);
            b_stall = ($urandom_range(0, 7) == 0); b_flush = ($urandom_range(0, 15) == 0);
            #1;
            n_checks++; if (a_occ !== 2'(ma_q.size()) || a_out_valid !== (ma_q.size() != 0)) begin n_fail++; $display("FAIL rnd_a_occ c%0d: got occ=%0d v=%b want occ=%0d", c, a_occ, a_out_valid, ma_q.size()); end
            n_checks++; if (a_in_ready !== (ma_q.size() < 2)) begin n_fail++; $display("FAIL rnd_a_ready c%0d: got %b want %b", c, a_in_ready, ma_q.size() < 2); end
            if (ma_q.size() != 0) begin
                n_checks++; if (a_out_data !== ma_q[0]) begin n_fail++; $display("FAIL rnd_a_data c%0d: got %h want %h", c, a_out_data, ma_q[0]); end
            end
            n_checks++; if (a_cnt !== 16'(ma_cnt)) begin n_fail++; $display("FAIL rnd_a_cnt c%0d: got %0d want %0d", c, a_cnt, ma_cnt); end
            n_checks++; if (b_occ !== 2'(mb_q.size()) || b_out_valid !== (mb_q.size() != 0)) begin n_fail++; $display("FAIL rnd_b_occ c%0d: got occ=%0d v=%b want occ=%0d", c, b_occ, b_out_valid, mb_q.size()); end
            n_checks++; if (b_in_ready !== (!(b_hold | b_stall) && (mb_q.size() == 0 || b_out_ready))) begin n_fail++; $display("FAIL rnd_b_ready c%0d: got %b", c, b_in_ready); end
            if (mb_q.size() != 0) begin
                n_checks++; if (b_out_data !== mb_q[0]) begin n_fail++; $display("FAIL rnd_b_data c%0d: got %h want %h", c, b_out_data, mb_q[0]); end
            end
            n_checks++; if (b_cnt !== 4'(mb_cnt)) begin n_fail++; $display("FAIL rnd_b_cnt c%0d: got %0d want %0d", c, b_cnt, mb_cnt); end
            step();
        end
        $display("test_random done");
    endtask

    initial begin
        pa = 64'h0000_0004_0000_0013;
        pb = 64'h0000_0008_00A0_0093;
        pc = 64'h0000_000C_0010_8113;
        pd = 64'h0000_0010_FFF0_0193;
        ma_cnt = 0; mb_cnt = 0;
        rst = 1;
        idle();
        test_reset();
        test_basic();
        test_skid_fill();
        test_freeze();
        test_flush();
        test_cnt_saturate();
        test_async_reset();
        test_skid0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
